// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared single-cycle ALU.
// One operation in flight at a time: IDLE -> EXEC -> RESP.
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_out,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        ptr;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  op_q;
  logic        id_q;
  logic [31:0] res_q;
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  logic take;
  logic gnt1;
  logic done;

  always_comb begin
    take = (state == IDLE) && !rst
         && (req0_valid || req1_valid);
    // req1 wins alone, or on a tie when the pointer favours it
    gnt1 = req1_valid && (!req0_valid || ptr);
    done = (state == RESP) && rsp_ready;
  end

  assign req0_ready = take && !gnt1;
  assign req1_ready = take && gnt1;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = res_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = 5'd0;
    if (state == EXEC) begin
      alu_a  = a_q;
      alu_b  = b_q;
      alu_op = op_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= RR_INIT;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 5'd0;
      id_q  <= 1'b0;
      res_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state <= EXEC;
            id_q  <= gnt1;
            a_q   <= gnt1 ? req1_a  : req0_a;
            b_q   <= gnt1 ? req1_b  : req0_b;
            op_q  <= gnt1 ? req1_op : req0_op;
          end
        end
        EXEC: begin
          res_q <= alu_out;
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
            ptr   <= ~id_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else if (done) begin
      if (!id_q && cnt0_q != 16'hFFFF)
        cnt0_q <= cnt0_q + 16'd1;
      if (id_q && cnt1_q != 16'hFFFF)
        cnt1_q <= cnt1_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised + directed bench for alu_arbiter with a
// transaction-level reference model and a stand-in ALU.
module tb_alu_arbiter;

  localparam logic RR_INIT = 1'b0;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [4:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [4:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_out;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int          age;
  bit          pri;
  int          c0;
  int          c1;
  bit          t_id;
  logic [31:0] t_a;
  logic [31:0] t_b;
  logic [4:0]  t_op;

  alu_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clk(clk),
    .rst(rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a(req0_a),
    .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a(req1_a),
    .req1_b(req1_b),
    .req1_op(req1_op),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_out(alu_out),
    .cnt0(cnt0),
    .cnt1(cnt1)
  );

  function automatic logic [31:0] alu_ref(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  op
  );
    case (op)
      5'd0: return a & b;
      5'd1: return a + b;
      5'd2: return a - b;
      5'd3: return a | b;
      5'd4: return {31'd0, $signed(a) < $signed(b)};
      5'd5: return a ^ b;
      5'd6: return ~(a | b);
      default: return (a + b) ^ {27'd0, op};
    endcase
  endfunction

  assign alu_out = alu_ref(alu_a, alu_b, alu_op);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // inputs are set just after a falling edge; check, advance model, wait
  task automatic tick();
    bit g0;
    bit g1;
    #1;
    if (rst) begin
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_cnt1", cnt1, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_alu_a", alu_a, 0);
      age = -1;
      pri = RR_INIT;
      c0  = 0;
      c1  = 0;
    end else begin
      g0 = (age < 0) && req0_valid && (!req1_valid || !pri);
      g1 = (age < 0) && req1_valid && (!req0_valid || pri);
      chk("ready0", req0_ready, g0);
      chk("ready1", req1_ready, g1);
      if (age == 0) begin
        chk("exec_alu_a", alu_a, t_a);
        chk("exec_alu_b", alu_b, t_b);
        chk("exec_alu_op", alu_op, t_op);
      end else begin
        chk("nop_alu_a", alu_a, 0);
        chk("nop_alu_b", alu_b, 0);
        chk("nop_alu_op", alu_op, 0);
      end
      chk("rsp_valid", rsp_valid, age >= 1);
      if (age >= 1) begin
        chk("rsp_data", rsp_data, alu_ref(t_a, t_b, t_op));
        chk("rsp_id", rsp_id, t_id);
      end
      chk("cnt0", cnt0, c0);
      chk("cnt1", cnt1, c1);
      if (g0 || g1) begin
        t_id = g1;
        t_a  = g1 ? req1_a  : req0_a;
        t_b  = g1 ? req1_b  : req0_b;
        t_op = g1 ? req1_op : req0_op;
        age  = 0;
      end else if (age == 0) begin
        age = 1;
      end else if (age >= 1 && rsp_ready) begin
        if (t_id) c1 = (c1 < 65535) ? c1 + 1 : c1;
        else      c0 = (c0 < 65535) ? c0 + 1 : c0;
        pri = !t_id;
        age = -1;
      end else if (age >= 1) begin
        age++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_in();
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready = 1;
    age = -1; pri = RR_INIT; c0 = 0; c1 = 0;
    t_id = 0; t_a = 0; t_b = 0; t_op = 0;
    @(negedge clk);
    tick();
    rst = 0;

    // single request: 5 + 3
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 1;
    tick();
    req0_valid = 0; req0_a = 32'hDEAD; req0_op = 5;
    tick();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_data", rsp_data, 8);
    chk("single_rsp_id", rsp_id, 0);
    tick();
    tick();
    chk("single_cnt0", cnt0, 1);

    // contention from a fresh reset
    do_reset();
    req0_valid = 1; req0_a = 10; req0_b = 4; req0_op = 2;
    req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 5;
    for (int i = 0; i < 12; i++) tick();
    chk("cont_cnt0", cnt0, 2);
    chk("cont_cnt1", cnt1, 2);

    // backpressure with both requesters waiting
    rsp_ready = 0;
    for (int i = 0; i < 8; i++) tick();
    rsp_ready = 1;
    tick();
    idle_in();
    tick();
    tick();

    // signed wrap and NOR
    req0_valid = 1; req0_a = 32'h7FFFFFFF; req0_b = 1; req0_op = 1;
    tick();
    idle_in();
    tick();
    chk("wrap_add", rsp_data, 32'h80000000);
    tick();
    req1_valid = 1; req1_a = 0; req1_b = 0; req1_op = 6;
    tick();
    idle_in();
    tick();
    chk("nor_zero", rsp_data, 32'hFFFFFFFF);
    tick();

    // reset while in EXEC
    do_reset();
    req1_valid = 1; req1_a = 7; req1_b = 9; req1_op = 1;
    tick();
    idle_in();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("rexec_cnt1", cnt1, 0);
    req0_valid = 1; req1_valid = 1;
    tick();
    idle_in();
    for (int i = 0; i < 3; i++) tick();
    chk("rexec_first_grant", cnt0, 1);

    // random traffic, including undefined opcodes and stray resets
    for (int i = 0; i < 3000; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a  = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
      req0_b  = $urandom;
      req0_op = 5'($urandom_range(0, 31));
      req1_a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      req1_b  = $urandom;
      req1_op = 5'($urandom_range(0, 31));
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    rsp_ready = 1;

    // saturation of the requester 1 counter
    do_reset();
    req1_valid = 1; req1_a = 1; req1_b = 2; req1_op = 1;
    for (int i = 0; i < 30; i++) tick();
    dut.cnt1_q = 16'hFFFC;
    c1 = 32'hFFFC;
    for (int i = 0; i < 30; i++) tick();
    chk("sat_cnt1", cnt1, 16'hFFFF);
    idle_in();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
